// File: rtl/sw_count_ctrl.sv
// sw_count_ctrl: registered up/down display counter with start/stop, clear and load keys.
// Optional per-key debouncer enabled by defining SW_COUNT_DEBOUNCE_EN.
module sw_count_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 10,
    parameter int MAX       = 999,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key_n,
    input  logic [9:0] sw,
    input  logic       dir,
    output logic [9:0] count,
    output logic       running,
    output logic       wrap
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(DIV);
    localparam logic [9:0] MAXV = 10'(MAX);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic {STOP, RUN} state_t;

    state_t        state_q, state_d;
    logic [2:0]    s1_q, s2_q, prev_q, lvl, press;
    logic [PW-1:0] pre_q, pre_d;
    logic [9:0]    count_q, count_d;
    logic          wrap_q, wrap_d, tick;

    if (DIV < 2 || MAX < 0 || MAX > 1023 || DB_CYCLES < 1) begin : g_bad_params
        $error("sw_count_ctrl: illegal parameter set");
    end

`ifdef SW_COUNT_DEBOUNCE_EN
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

    logic [2:0][DW-1:0] db_q, db_d;
    logic [2:0]         lvl_q, lvl_d;

    // Counter runs only while the synced key disagrees with the accepted level.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_d[i]  = (s2_q[i] == lvl_q[i] || db_q[i] == DB_LAST) ? '0 : db_q[i] + 1'b1;
            lvl_d[i] = (s2_q[i] != lvl_q[i] && db_q[i] == DB_LAST) ? s2_q[i] : lvl_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q  <= '0;
            lvl_q <= '1;
        end else begin
            db_q  <= db_d;
            lvl_q <= lvl_d;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = s2_q;
`endif

    assign press = prev_q & ~lvl;
    assign tick  = state_q == RUN && pre_q == PRE_LAST;

    always_comb begin
        state_d = press[0] ? (state_q == RUN ? STOP : RUN) : state_q;
        pre_d   = (press[1] || press[2]) ? '0 : state_q != RUN ? pre_q : tick ? '0 : pre_q + 1'b1;
        count_d = press[1] ? '0
                : press[2] ? (sw > MAXV ? MAXV : sw)
                : !tick    ? count_q
                : dir      ? (count_q == MAXV ? '0 : count_q + 10'd1)
                :            (count_q == '0 ? MAXV : count_q - 10'd1);
        wrap_d  = tick && !press[1] && !press[2] && (dir ? count_q == MAXV : count_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '1;
            s2_q    <= '1;
            prev_q  <= '1;
            state_q <= STOP;
            pre_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            s1_q    <= key_n;
            s2_q    <= s1_q;
            prev_q  <= lvl;
            state_q <= state_d;
            pre_q   <= pre_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count   = count_q;
    assign running = state_q == RUN;
    assign wrap    = wrap_q;
endmodule
